// File: rtl/hdmi_packet_pkg.sv
// hdmi_packet_pkg: packet type codes, scheduler state and sample types shared by the HDMI audio packet path
package hdmi_packet_pkg;
    localparam logic [7:0] PKT_NULL      = 8'h00;
    localparam logic [7:0] PKT_ACR       = 8'h01;
    localparam logic [7:0] PKT_SAMPLE    = 8'h02;
    localparam logic [7:0] PKT_INFOFRAME = 8'h84;

    localparam int SAMPLE_W     = 24;
    localparam int IEC_FRAMES   = 192;

    typedef enum logic {
        STARTUP = 1'b0,
        RUN     = 1'b1
    } sched_state_t;

    // [0] left, [1] right
    typedef logic [1:0][SAMPLE_W-1:0] stereo_sample_t;

    // IEC 60958 block frame index, wraps 191 -> 0
    function automatic logic [7:0] frame_next(input logic [7:0] f);
        return (f == 8'(IEC_FRAMES - 1)) ? 8'd0 : f + 8'd1;
    endfunction
endpackage

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: synchronous FIFO buffering stereo samples between the audio source and the packet scheduler
//   clk, rst_n          clock, asynchronous active-low reset (discards contents)
//   push, push_data     write request; ignored when full, even with a simultaneous pop
//   pop, head           read request and current head entry (valid when !empty)
//   full, empty, level  occupancy status
module audio_sample_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/audio_packet_scheduler.sv
// audio_packet_scheduler: picks the packet type for each HDMI data-island slot (ACR, audio sample, infoframe, null)
//   clk_pixel, reset_n       pixel clock, asynchronous active-low reset
//   frame_start              video frame pulse; leaves STARTUP, and schedules an audio infoframe
//   packet_enable            one-cycle slot grant pulse
//   audio_sample_word_in     stereo sample in, with audio_sample_valid / audio_sample_ready handshake
//   packet_type              registered slot decision, held until the next packet_enable
//   audio_sample_word_out    sample carried by the current SAMPLE packet (zero for other packets)
//   frame_counter            IEC 60958 frame index of the sample being carried
//   fifo_level               buffered sample count
// Build option: define HDMI_AUDIO_INFOFRAME_EN to schedule audio infoframes once per frame.
module audio_packet_scheduler
    import hdmi_packet_pkg::*;
#(
    parameter int ACR_INTERVAL      = 25200,
    parameter int SAMPLE_FIFO_DEPTH = 4
) (
    input  logic                                 clk_pixel,
    input  logic                                 reset_n,
    input  logic                                 frame_start,
    input  logic                                 packet_enable,
    input  stereo_sample_t                       audio_sample_word_in,
    input  logic                                 audio_sample_valid,
    output logic                                 audio_sample_ready,
    output logic [7:0]                           packet_type,
    output stereo_sample_t                       audio_sample_word_out,
    output logic [7:0]                           frame_counter,
    output logic [$clog2(SAMPLE_FIFO_DEPTH):0]   fifo_level
);
    localparam int CW = $clog2(ACR_INTERVAL + 1);
    localparam logic [CW-1:0] ACR_RELOAD = CW'(ACR_INTERVAL - 1);

    sched_state_t    state_q;
    sched_state_t    state_d;
    logic [7:0]      grant;
    logic [CW-1:0]   acr_cnt;
    logic            acr_due;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;
    stereo_sample_t  fifo_head;
    logic [7:0]      frame_idx;
    logic            if_pending;
    logic            if_urgent;
    logic            sample_grant;

    assign acr_due            = acr_cnt == '0;
    assign audio_sample_ready = (state_q == RUN) && !fifo_full;
    assign sample_grant       = packet_enable && (grant == PKT_SAMPLE);
    assign fifo_pop           = sample_grant;

    audio_sample_fifo #(
        .WIDTH (2 * SAMPLE_W),
        .DEPTH (SAMPLE_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_pixel),
        .rst_n     (reset_n),
        .push      (audio_sample_valid && audio_sample_ready),
        .push_data (audio_sample_word_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n)
            state_q <= STARTUP;
        else
            state_q <= state_d;
    end

    // Fixed-priority slot arbitration; STARTUP only ever sees ACR or NULL
    always_comb begin
        state_d = state_q;
        grant   = PKT_NULL;
        if (state_q == STARTUP && frame_start)
            state_d = RUN;
        if (acr_due)
            grant = PKT_ACR;
        else if (state_q == RUN)
            grant = if_urgent   ? PKT_INFOFRAME :
                    !fifo_empty ? PKT_SAMPLE    :
                    if_pending  ? PKT_INFOFRAME : PKT_NULL;
    end

    // Reload on the granting edge so the next slot can never see a second ACR
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n)
            acr_cnt <= ACR_RELOAD;
        else
            acr_cnt <= (packet_enable && acr_due) ? ACR_RELOAD :
                       acr_due                    ? acr_cnt    : acr_cnt - CW'(1);
    end

`ifdef HDMI_AUDIO_INFOFRAME_EN
    logic [1:0] if_skip;

    assign if_urgent = if_pending && (if_skip >= 2'd2);

    // A new frame's request wins over clearing an older one on the same edge
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            if_pending <= 1'b0;
            if_skip    <= 2'd0;
        end else begin
            if (packet_enable && grant == PKT_INFOFRAME) begin
                if_pending <= 1'b0;
                if_skip    <= 2'd0;
            end else if (packet_enable && if_pending && if_skip != 2'd3) begin
                if_skip <= if_skip + 2'd1;
            end
            if (frame_start && state_q == RUN)
                if_pending <= 1'b1;
        end
    end
`else
    assign if_pending = 1'b0;
    assign if_urgent  = 1'b0;
`endif

    // Slot outputs hold from one packet_enable to the next
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            packet_type           <= PKT_NULL;
            audio_sample_word_out <= '0;
            frame_counter         <= 8'd0;
            frame_idx             <= 8'd0;
        end else if (packet_enable) begin
            packet_type           <= grant;
            audio_sample_word_out <= sample_grant ? fifo_head : '0;
            if (sample_grant) begin
                frame_counter <= frame_idx;
                frame_idx     <= frame_next(frame_idx);
            end
        end
    end
endmodule

// File: tb/tb_audio_packet_scheduler.sv
// tb_audio_packet_scheduler: randomized and directed checks of audio_packet_scheduler against a queue-based model
module tb_audio_packet_scheduler;
    import hdmi_packet_pkg::*;

    localparam int ACR   = 8;
    localparam int DEPTH = 4;
`ifdef HDMI_AUDIO_INFOFRAME_EN
    localparam bit IF_EN = 1'b1;
`else
    localparam bit IF_EN = 1'b0;
`endif

    logic                      clk_pixel = 1'b0;
    logic                      reset_n = 1'b1;
    logic                      frame_start = 1'b0;
    logic                      packet_enable = 1'b0;
    logic [1:0][23:0]          audio_sample_word_in = '0;
    logic                      audio_sample_valid = 1'b0;
    logic                      audio_sample_ready;
    logic [7:0]                packet_type;
    logic [1:0][23:0]          audio_sample_word_out;
    logic [7:0]                frame_counter;
    logic [$clog2(DEPTH):0]    fifo_level;

    audio_packet_scheduler #(
        .ACR_INTERVAL      (ACR),
        .SAMPLE_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_pixel             (clk_pixel),
        .reset_n               (reset_n),
        .frame_start           (frame_start),
        .packet_enable         (packet_enable),
        .audio_sample_word_in  (audio_sample_word_in),
        .audio_sample_valid    (audio_sample_valid),
        .audio_sample_ready    (audio_sample_ready),
        .packet_type           (packet_type),
        .audio_sample_word_out (audio_sample_word_out),
        .frame_counter         (frame_counter),
        .fifo_level            (fifo_level)
    );

    always #5 clk_pixel = ~clk_pixel;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: time since last ACR, sample queue, frame index, infoframe bookkeeping
    logic [47:0] m_q[$];
    int          m_age;
    bit          m_run;
    bit          m_pend;
    int          m_skip;
    logic [7:0]  m_fidx;
    logic [7:0]  exp_type;
    logic [47:0] exp_word;
    logic [7:0]  exp_fc;
    bit          granted;
    logic [7:0]  last_g;
    int          cyc;
    int          last_acr;
    int          acr_gap;

    task automatic model_reset();
        m_q.delete();
        m_age = 0; m_run = 0; m_pend = 0; m_skip = 0; m_fidx = 0;
        exp_type = PKT_NULL; exp_word = '0; exp_fc = 0;
        granted = 0; last_g = PKT_NULL; last_acr = -1000; acr_gap = 1000;
    endtask

    task automatic cycle(input bit fs, input bit pe, input bit v, input logic [47:0] w);
        logic [7:0] g;
        bit push;
        frame_start = fs; packet_enable = pe; audio_sample_valid = v; audio_sample_word_in = w;
        push = v && m_run && (m_q.size() < DEPTH);
        g = PKT_NULL;
        granted = pe;
        if (pe) begin
            if (m_age >= ACR - 1) g = PKT_ACR;
            else if (!m_run) g = PKT_NULL;
            else if (m_pend && m_skip >= 2) g = PKT_INFOFRAME;
            else if (m_q.size() != 0) g = PKT_SAMPLE;
            else if (m_pend) g = PKT_INFOFRAME;
            exp_type = g;
            exp_word = '0;
            if (g == PKT_SAMPLE) begin
                exp_word = m_q.pop_front();
                exp_fc = m_fidx;
                m_fidx = (m_fidx == 8'd191) ? 8'd0 : m_fidx + 8'd1;
            end
            if (m_pend) begin
                if (g == PKT_INFOFRAME) begin m_pend = 0; m_skip = 0; end
                else if (m_skip < 3) m_skip++;
            end
            if (g == PKT_ACR) begin acr_gap = cyc - last_acr; last_acr = cyc; end
            last_g = g;
        end
        m_age = (pe && g == PKT_ACR) ? 0 : m_age + 1;
        if (IF_EN && fs && m_run) m_pend = 1;
        if (fs) m_run = 1;
        if (push) m_q.push_back(w);
        cyc++;
        @(posedge clk_pixel);
        @(negedge clk_pixel);
        frame_start = 0; packet_enable = 0; audio_sample_valid = 0;
    endtask

    function automatic logic [47:0] rnd_word();
        return {$urandom_range(0, 24'hFFFFFF), $urandom_range(0, 24'hFFFFFF)};
    endfunction

    task automatic test_reset();
        #1 reset_n = 0;
        model_reset();
        @(negedge clk_pixel);
        n_checks++; if (packet_type !== PKT_NULL) begin n_fail++; $display("FAIL reset_type: got %h expected %h", packet_type, PKT_NULL); end
        n_checks++; if (audio_sample_word_out !== 48'h0) begin n_fail++; $display("FAIL reset_word: got %h expected 0", audio_sample_word_out); end
        n_checks++; if (frame_counter !== 8'd0) begin n_fail++; $display("FAIL reset_fc: got %0d expected 0", frame_counter); end
        n_checks++; if (fifo_level !== 0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        n_checks++; if (audio_sample_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", audio_sample_ready); end
        @(negedge clk_pixel);
        reset_n = 1;
        model_reset();
    endtask

    task automatic test_startup();
        for (int i = 0; i < 12; i++) begin
            cycle(0, 1, 1, rnd_word());
            n_checks++; if (packet_type !== exp_type) begin n_fail++; $display("FAIL startup_type: got %h expected %h", packet_type, exp_type); end
            n_checks++; if (audio_sample_ready !== 1'b0) begin n_fail++; $display("FAIL startup_ready: got %b expected 0", audio_sample_ready); end
            n_checks++; if (fifo_level !== 0) begin n_fail++; $display("FAIL startup_level: got %0d expected 0", fifo_level); end
        end
        cycle(1, 0, 0, '0);
        n_checks++; if (audio_sample_ready !== 1'b1) begin n_fail++; $display("FAIL startup_exit_ready: got %b expected 1", audio_sample_ready); end
    endtask

    task automatic test_acr();
        int n_acr = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(0, (i % 4) == 0, 0, '0);
            if (granted) begin
                n_checks++; if (packet_type !== exp_type) begin n_fail++; $display("FAIL acr_type: got %h expected %h", packet_type, exp_type); end
                if (last_g == PKT_ACR) begin
                    n_acr++;
                    n_checks++; if (acr_gap < ACR) begin n_fail++; $display("FAIL acr_gap: got %0d expected >= %0d", acr_gap, ACR); end
                end
            end
        end
        n_checks++; if (n_acr < 4) begin n_fail++; $display("FAIL acr_count: got %0d expected >= 4", n_acr); end
    endtask

    task automatic test_fifo_full();
        bit got = 0;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (audio_sample_ready !== (i < 4)) begin n_fail++; $display("FAIL full_ready%0d: got %b expected %b", i, audio_sample_ready, i < 4); end
            cycle(0, 0, 1, rnd_word());
        end
        n_checks++; if (fifo_level !== 4) begin n_fail++; $display("FAIL full_level: got %0d expected 4", fifo_level); end
        n_checks++; if (audio_sample_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_hold: got %b expected 0", audio_sample_ready); end
        for (int i = 0; i < 10 && !got; i++) begin
            cycle(0, 1, 0, '0);
            got = (last_g == PKT_SAMPLE);
        end
        n_checks++; if (!got) begin n_fail++; $display("FAIL full_grant_timeout: got none expected SAMPLE"); end
        n_checks++; if (audio_sample_word_out !== exp_word) begin n_fail++; $display("FAIL full_word: got %h expected %h", audio_sample_word_out, exp_word); end
        n_checks++; if (fifo_level !== 3) begin n_fail++; $display("FAIL full_level_after: got %0d expected 3", fifo_level); end
        n_checks++; if (audio_sample_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after: got %b expected 1", audio_sample_ready); end
    endtask

    task automatic test_infoframe();
        bit got = 0;
        logic [7:0] want [3];
        want[0] = PKT_SAMPLE; want[1] = PKT_SAMPLE; want[2] = IF_EN ? PKT_INFOFRAME : PKT_SAMPLE;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle(0, 1, 1, rnd_word());
            got = (last_g == PKT_ACR);
        end
        n_checks++; if (!got) begin n_fail++; $display("FAIL info_acr_timeout: got none expected ACR"); end
        cycle(1, 0, 1, rnd_word());
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 1, rnd_word());
            n_checks++; if (packet_type !== want[i]) begin n_fail++; $display("FAIL info_slot%0d: got %h expected %h", i, packet_type, want[i]); end
            n_checks++; if (packet_type !== exp_type) begin n_fail++; $display("FAIL info_model%0d: got %h expected %h", i, packet_type, exp_type); end
        end
    endtask

    task automatic test_priority();
        logic [7:0] want [3];
        want[0] = PKT_ACR; want[1] = PKT_SAMPLE; want[2] = IF_EN ? PKT_INFOFRAME : PKT_SAMPLE;
        cycle(1, 0, 1, rnd_word());
        for (int i = 0; i < 2 * ACR && m_age < ACR - 1; i++)
            cycle(0, 0, 1, rnd_word());
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 1, rnd_word());
            n_checks++; if (packet_type !== want[i]) begin n_fail++; $display("FAIL prio_slot%0d: got %h expected %h", i, packet_type, want[i]); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, rnd_word());
            n_checks++; if (packet_type !== exp_type) begin n_fail++; $display("FAIL rnd_type @%0d: got %h expected %h", cyc, packet_type, exp_type); end
            n_checks++; if (audio_sample_word_out !== exp_word) begin n_fail++; $display("FAIL rnd_word @%0d: got %h expected %h", cyc, audio_sample_word_out, exp_word); end
            n_checks++; if (frame_counter !== exp_fc) begin n_fail++; $display("FAIL rnd_fc @%0d: got %0d expected %0d", cyc, frame_counter, exp_fc); end
            n_checks++; if (fifo_level !== m_q.size()) begin n_fail++; $display("FAIL rnd_level @%0d: got %0d expected %0d", cyc, fifo_level, m_q.size()); end
            n_checks++; if (audio_sample_ready !== (m_run && m_q.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_ready @%0d: got %b expected %b", cyc, audio_sample_ready, m_run && m_q.size() < DEPTH); end
        end
    endtask

    task automatic test_reset_mid();
        bit got = 0;
        for (int i = 0; i < 200 && m_q.size() != 0; i++)
            cycle(0, 1, 0, '0);
        n_checks++; if (fifo_level !== 0) begin n_fail++; $display("FAIL mid_drain: got %0d expected 0", fifo_level); end
        for (int i = 0; i < 4; i++)
            cycle(0, 0, 1, rnd_word());
        for (int i = 0; i < 20 && !got; i++) begin
            cycle(0, 1, 0, '0);
            got = (last_g == PKT_SAMPLE);
        end
        n_checks++; if (fifo_level !== 3) begin n_fail++; $display("FAIL mid_level3: got %0d expected 3", fifo_level); end
        n_checks++; if (packet_type !== PKT_SAMPLE) begin n_fail++; $display("FAIL mid_hold_type: got %h expected %h", packet_type, PKT_SAMPLE); end
        @(posedge clk_pixel);
        #2 reset_n = 0;
        #1;
        n_checks++; if (packet_type !== PKT_NULL) begin n_fail++; $display("FAIL mid_type: got %h expected %h", packet_type, PKT_NULL); end
        n_checks++; if (audio_sample_word_out !== 48'h0) begin n_fail++; $display("FAIL mid_word: got %h expected 0", audio_sample_word_out); end
        n_checks++; if (frame_counter !== 8'd0) begin n_fail++; $display("FAIL mid_fc: got %0d expected 0", frame_counter); end
        n_checks++; if (fifo_level !== 0) begin n_fail++; $display("FAIL mid_level: got %0d expected 0", fifo_level); end
        n_checks++; if (audio_sample_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %b expected 0", audio_sample_ready); end
        @(negedge clk_pixel);
        reset_n = 1;
        model_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(0, (i % 2) == 0, 1, rnd_word());
            n_checks++; if (packet_type === PKT_SAMPLE || packet_type !== exp_type) begin n_fail++; $display("FAIL mid_startup_type: got %h expected %h", packet_type, exp_type); end
            n_checks++; if (audio_sample_ready !== 1'b0) begin n_fail++; $display("FAIL mid_startup_ready: got %b expected 0", audio_sample_ready); end
        end
        cycle(1, 0, 0, '0);
        n_checks++; if (audio_sample_ready !== 1'b1) begin n_fail++; $display("FAIL mid_run_ready: got %b expected 1", audio_sample_ready); end
    endtask

    task automatic test_frame_wrap();
        int k = 0;
        for (int i = 0; i < 3000 && k < 193; i++) begin
            cycle(0, (i % 2) == 1, 1, rnd_word());
            if (granted && last_g == PKT_SAMPLE) begin
                n_checks++; if (frame_counter !== 8'(k % 192)) begin n_fail++; $display("FAIL wrap_fc%0d: got %0d expected %0d", k, frame_counter, k % 192); end
                n_checks++; if (audio_sample_word_out !== exp_word) begin n_fail++; $display("FAIL wrap_word%0d: got %h expected %h", k, audio_sample_word_out, exp_word); end
                k++;
            end
        end
        n_checks++; if (k != 193) begin n_fail++; $display("FAIL wrap_timeout: got %0d grants expected 193", k); end
    endtask

    initial begin
        cyc = 0;
        model_reset();
        test_reset();
        test_startup();
        test_acr();
        test_fifo_full();
        test_infoframe();
        test_priority();
        test_random();
        test_reset_mid();
        test_frame_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/audio_packet_scheduler.md
AUDIO_PACKET_SCHEDULER -- requirements
Module: audio_packet_scheduler

Interface
REQ-001 SHALL have parameter ACR_INTERVAL, default 25200, meaning pixel clocks between Audio Clock Regeneration (ACR) packets.
REQ-002 SHALL have parameter SAMPLE_FIFO_DEPTH, default 4, meaning stereo-sample buffer entries; power of 2, at least 2.
REQ-003 SHALL have port clk_pixel, input, 1 bit: pixel clock, the only clock.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port frame_start, input, 1 bit: one-cycle pulse at start of each video frame.
REQ-006 SHALL have port packet_enable, input, 1 bit: one-cycle pulse granting one data-island packet slot.
REQ-007 SHALL have port audio_sample_word_in, input, 2x24 bits: [0] left, [1] right.
REQ-008 SHALL have ports audio_sample_valid (input, 1 bit) and audio_sample_ready (output, 1 bit): sample handshake.
REQ-009 SHALL have port packet_type, output, 8 bits: packet for current slot.
REQ-010 SHALL have port audio_sample_word_out, output, 2x24 bits: sample carried by current audio sample packet.
REQ-011 SHALL have port frame_counter, output, 8 bits: IEC 60958 frame index, 0..191.
REQ-012 SHALL have port fifo_level, output, $clog2(SAMPLE_FIFO_DEPTH)+1 bits: buffered sample count.

Function
REQ-013 SHALL encode packet types as NULL 8'h00, ACR 8'h01, SAMPLE 8'h02, INFOFRAME 8'h84.
REQ-014 SHALL accept a sample on clk_pixel edges where audio_sample_valid && audio_sample_ready; audio_sample_ready = (state==RUN) && !full; push is refused when full, even with a simultaneous pop.
REQ-015 SHALL implement FSM STARTUP -> RUN on the first frame_start; RUN is left only by reset.
REQ-016 SHALL, in STARTUP, grant only ACR or NULL, and hold audio_sample_ready low.
REQ-017 SHALL implement the ACR down-counter:
- loads ACR_INTERVAL-1 at reset;
- decrements each cycle and saturates at 0;
- acr_due = (count==0);
- reloads on the cycle after an ACR grant; a grant and expiry in the same cycle yield exactly one ACR.
REQ-018 SHALL set infoframe_pending on frame_start in RUN and clear it on an INFOFRAME grant; frame_start while already pending has no extra effect.
REQ-019 SHALL count slots lost by a pending infoframe (skip count, saturating at 3); it becomes urgent at 2 and clears on grant.
REQ-020 SHALL arbitrate on each packet_enable with fixed priority: ACR if acr_due > INFOFRAME if urgent > SAMPLE if FIFO non-empty > INFOFRAME if pending > NULL.
REQ-021 SHALL register packet_type and audio_sample_word_out one cycle after packet_enable and hold them until the next packet_enable.
REQ-022 SHALL pop the FIFO head into audio_sample_word_out on a SAMPLE grant.
REQ-023 SHALL present frame_counter with the granted sample, then advance it mod 192 (191 -> 0).
REQ-024 SHALL treat packet_enable with all sources idle as a NULL grant, with no state change except the infoframe skip count.

Reset
REQ-025 SHALL, while reset_n is low, drive packet_type=NULL, audio_sample_word_out=0, frame_counter=0, fifo_level=0 and audio_sample_ready=0, with state STARTUP, pending/skip cleared and the ACR counter per REQ-017.
REQ-026 SHALL, on reset assertion mid-slot, abandon the current grant immediately and discard FIFO contents.

Configuration
REQ-027 SHALL schedule infoframes per REQ-018/019 when macro HDMI_AUDIO_INFOFRAME_EN is defined.
REQ-028 SHALL, without HDMI_AUDIO_INFOFRAME_EN, never grant INFOFRAME, remove the pending/skip logic, and use frame_start only for the STARTUP exit.

Structure
REQ-029 SHALL take the packet type constants and the state enum from shared package hdmi_packet_pkg.
REQ-030 SHALL place the sample buffer in sub-module audio_sample_fifo (synchronous FIFO providing push, pop, full, empty and level).

Verification
REQ-031 SHALL cover ACR_INTERVAL=8, RUN, packet_enable every 4 cycles: ACR granted once the counter reaches 0, then again no sooner than 8 cycles after the reload.
REQ-032 SHALL cover 5 pushes into an empty FIFO with depth 4: 4 accepted, ready low on the 5th, fifo_level=4; after one SAMPLE grant, level 3 and ready high.
REQ-033 SHALL cover 193 sample grants: frame_counter presents 0..191 then 0, and the outputs carry the pushed values in order.
REQ-034 SHALL cover frame_start with the FIFO continuously non-empty: SAMPLE wins 2 slots, then the 3rd slot is INFOFRAME; with the macro undefined, INFOFRAME never appears.
REQ-035 SHALL cover reset_n pulsed low mid-hold with FIFO level 3: outputs at reset values, level 0, STARTUP; no SAMPLE granted until the next frame_start.
REQ-036 SHALL cover acr_due, a pending infoframe and a non-empty FIFO on the same packet_enable: ACR granted, and the skip count increments.
